// File: rtl/cdb_pkg.sv
`timescale 1ns/1ps
// Shared Common Data Bus constants: widths and source indices.
// Issue queues import these too when snooping CDB tags.
package cdb_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int TAG_WIDTH   = 6;
  localparam int NUM_CDB_SRC = 4;

  localparam int SRC_INT  = 0;
  localparam int SRC_MULT = 1;
  localparam int SRC_DIV  = 2;
  localparam int SRC_LSQ  = 3;

endpackage

// File: rtl/rr_arbiter4.sv
`timescale 1ns/1ps
// Four-way round-robin arbiter with an internal priority pointer.
// The search starts at the pointer; the pointer moves past the winner only when advance is high.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] grant
);

  logic [1:0] ptr;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = '0;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      grant[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= win + 2'd1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
// CDB producer: one holding register per execution unit, round-robin selection,
// and a registered broadcast onto the PRF write port.
module cdb_arbiter #(
  parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  int_valid,
  output logic                  int_ready,
  input  logic [TAG_WIDTH-1:0]  int_tag,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic                  mult_valid,
  output logic                  mult_ready,
  input  logic [TAG_WIDTH-1:0]  mult_tag,
  input  logic [DATA_WIDTH-1:0] mult_data,
  input  logic                  div_valid,
  output logic                  div_ready,
  input  logic [TAG_WIDTH-1:0]  div_tag,
  input  logic [DATA_WIDTH-1:0] div_data,
  input  logic                  lsq_valid,
  output logic                  lsq_ready,
  input  logic [TAG_WIDTH-1:0]  lsq_tag,
  input  logic [DATA_WIDTH-1:0] lsq_data,
  output logic                  cdb_w_en,
  output logic [TAG_WIDTH-1:0]  cdb_w_addr,
  output logic [DATA_WIDTH-1:0] cdb_din,
  output logic [3:0]            cdb_pending
);

  import cdb_pkg::*;

  logic [NUM_CDB_SRC-1:0] valid_vec;
  logic [NUM_CDB_SRC-1:0] ready_vec;
  logic [NUM_CDB_SRC-1:0] accept;
  logic [NUM_CDB_SRC-1:0] grant;
  logic [NUM_CDB_SRC-1:0] hold_v;
  logic [TAG_WIDTH-1:0]   in_tag    [NUM_CDB_SRC];
  logic [DATA_WIDTH-1:0]  in_data   [NUM_CDB_SRC];
  logic [TAG_WIDTH-1:0]   hold_tag  [NUM_CDB_SRC];
  logic [DATA_WIDTH-1:0]  hold_data [NUM_CDB_SRC];
  logic [TAG_WIDTH-1:0]   win_tag;
  logic [DATA_WIDTH-1:0]  win_data;

  assign valid_vec = {lsq_valid, div_valid, mult_valid, int_valid};

  assign in_tag[SRC_INT]   = int_tag;
  assign in_tag[SRC_MULT]  = mult_tag;
  assign in_tag[SRC_DIV]   = div_tag;
  assign in_tag[SRC_LSQ]   = lsq_tag;
  assign in_data[SRC_INT]  = int_data;
  assign in_data[SRC_MULT] = mult_data;
  assign in_data[SRC_DIV]  = div_data;
  assign in_data[SRC_LSQ]  = lsq_data;

  // A granted source may refill in the same cycle its held entry leaves.
  assign ready_vec = {NUM_CDB_SRC{!flush}} & (~hold_v | grant);
  assign accept    = valid_vec & ready_vec;

  assign int_ready   = ready_vec[SRC_INT];
  assign mult_ready  = ready_vec[SRC_MULT];
  assign div_ready   = ready_vec[SRC_DIV];
  assign lsq_ready   = ready_vec[SRC_LSQ];
  assign cdb_pending = hold_v;

  rr_arbiter4 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (hold_v),
    .advance (!flush),
    .grant   (grant)
  );

  always_comb begin
    win_tag  = '0;
    win_data = '0;
    for (int s = 0; s < NUM_CDB_SRC; s++) begin
      if (grant[s]) begin
        win_tag  = hold_tag[s];
        win_data = hold_data[s];
      end
    end
  end

  // Tag 0 results have no destination, so they complete the handshake without occupying a slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v <= '0;
      for (int s = 0; s < NUM_CDB_SRC; s++) begin
        hold_tag[s]  <= '0;
        hold_data[s] <= '0;
      end
    end else if (flush) begin
      hold_v <= '0;
    end else begin
      for (int s = 0; s < NUM_CDB_SRC; s++) begin
        if (accept[s] && (in_tag[s] != '0)) begin
          hold_v[s]    <= 1'b1;
          hold_tag[s]  <= in_tag[s];
          hold_data[s] <= in_data[s];
        end else if (grant[s]) begin
          hold_v[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cdb_w_en   <= 1'b0;
      cdb_w_addr <= '0;
      cdb_din    <= '0;
    end else if (flush) begin
      cdb_w_en <= 1'b0;
    end else if (|grant) begin
      cdb_w_en   <= 1'b1;
      cdb_w_addr <= win_tag;
      cdb_din    <= win_data;
    end else begin
      cdb_w_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
// Randomised plus directed bench for cdb_arbiter: a source-level reference model predicts
// ready/pending each cycle and queues expected broadcasts for an independent CDB monitor.
module tb_cdb_arbiter;

  localparam int DW = 32;
  localparam int TW = 6;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [3:0]    vld = '0;
  logic [TW-1:0] tg [4];
  logic [DW-1:0] dt [4];

  logic          int_valid, mult_valid, div_valid, lsq_valid;
  logic          int_ready, mult_ready, div_ready, lsq_ready;
  logic [TW-1:0] int_tag, mult_tag, div_tag, lsq_tag;
  logic [DW-1:0] int_data, mult_data, div_data, lsq_data;
  logic          cdb_w_en;
  logic [TW-1:0] cdb_w_addr;
  logic [DW-1:0] cdb_din;
  logic [3:0]    cdb_pending;
  logic [3:0]    rdy;

  int            n_checks = 0;
  int            n_pass = 0;
  int            edge_cnt = 0;
  exp_t          sbq [$];

  logic [3:0]    m_hv = '0;
  logic [TW-1:0] m_tag [4];
  logic [DW-1:0] m_data [4];
  int            m_ptr = 0;

  assign int_valid  = vld[0];
  assign mult_valid = vld[1];
  assign div_valid  = vld[2];
  assign lsq_valid  = vld[3];
  assign int_tag    = tg[0];
  assign mult_tag   = tg[1];
  assign div_tag    = tg[2];
  assign lsq_tag    = tg[3];
  assign int_data   = dt[0];
  assign mult_data  = dt[1];
  assign div_data   = dt[2];
  assign lsq_data   = dt[3];
  assign rdy        = {lsq_ready, div_ready, mult_ready, int_ready};

  cdb_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .int_valid   (int_valid),
    .int_ready   (int_ready),
    .int_tag     (int_tag),
    .int_data    (int_data),
    .mult_valid  (mult_valid),
    .mult_ready  (mult_ready),
    .mult_tag    (mult_tag),
    .mult_data   (mult_data),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .div_tag     (div_tag),
    .div_data    (div_data),
    .lsq_valid   (lsq_valid),
    .lsq_ready   (lsq_ready),
    .lsq_tag     (lsq_tag),
    .lsq_data    (lsq_data),
    .cdb_w_en    (cdb_w_en),
    .cdb_w_addr  (cdb_w_addr),
    .cdb_din     (cdb_din),
    .cdb_pending (cdb_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_hv  = '0;
    m_ptr = 0;
    for (int s = 0; s < 4; s++) begin
      m_tag[s]  = '0;
      m_data[s] = '0;
    end
    sbq.delete();
  endtask

  // Drive one cycle of inputs, check ready/pending against the model, then advance the model.
  task automatic applyStimulus(input logic [3:0] v, input logic [4*TW-1:0] t,
                               input logic [4*DW-1:0] d, input logic fl);
    int         g;
    int         s;
    logic [3:0] mr;
    @(negedge clk);
    vld   = v;
    flush = fl;
    for (int i = 0; i < 4; i++) begin
      tg[i] = t[i*TW +: TW];
      dt[i] = d[i*DW +: DW];
    end
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      s = (m_ptr + k) % 4;
      if (g < 0 && m_hv[s]) g = s;
    end
    for (int i = 0; i < 4; i++) begin
      mr[i] = !fl && (!m_hv[i] || (g == i));
    end
    checkOutput("ready", 64'(rdy), 64'(mr));
    checkOutput("pending", 64'(cdb_pending), 64'(m_hv));
    if (fl) begin
      m_hv = '0;
    end else begin
      if (g >= 0) begin
        sbq.push_back('{m_tag[g], m_data[g], edge_cnt + 1});
        m_hv[g] = 1'b0;
        m_ptr   = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (v[i] && mr[i] && (t[i*TW +: TW] != '0)) begin
          m_hv[i]   = 1'b1;
          m_tag[i]  = t[i*TW +: TW];
          m_data[i] = d[i*DW +: DW];
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, '0, '0, 1'b0);
  endtask

  // Monitor: every broadcast must match the head of the scoreboard, on the predicted edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      if (cdb_w_en) begin
        checkOutput("cdb_expected_any", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checkOutput("cdb_w_addr", 64'(cdb_w_addr), 64'(e.tag));
          checkOutput("cdb_din", 64'(cdb_din), 64'(e.data));
          checkOutput("cdb_cycle", 64'(edge_cnt), 64'(e.cyc));
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= edge_cnt) begin
        e = sbq.pop_front();
        checkOutput("cdb_missing", 64'(cdb_w_en), 64'd1);
      end
    end
  end

  initial begin
    logic [4*TW-1:0] t;
    logic [4*DW-1:0] d;
    logic [3:0]      v;
    for (int i = 0; i < 4; i++) begin
      tg[i] = '0;
      dt[i] = '0;
    end
    modelReset();

    #12;
    checkOutput("reset_w_en", 64'(cdb_w_en), 64'd0);
    checkOutput("reset_w_addr", 64'(cdb_w_addr), 64'd0);
    checkOutput("reset_din", 64'(cdb_din), 64'd0);
    checkOutput("reset_pending", 64'(cdb_pending), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single result");
    applyStimulus(4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}, {96'd0, 32'hDEADBEEF}, 1'b0);
    idle(4);

    $display("[TB] four simultaneous results");
    applyStimulus(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},
                  {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, 1'b0);
    idle(6);

    $display("[TB] fairness int/div");
    for (int i = 0; i < 10; i++) begin
      t = '0;
      d = '0;
      t[0*TW +: TW] = TW'(1 + i);
      t[2*TW +: TW] = TW'(20 + i);
      d[0*DW +: DW] = $urandom;
      d[2*DW +: DW] = $urandom;
      applyStimulus(4'b0101, t, d, 1'b0);
    end
    idle(4);

    $display("[TB] tag zero");
    applyStimulus(4'b1000, '0, {32'hCAFE_0000, 96'd0}, 1'b0);
    idle(3);

    $display("[TB] flush");
    applyStimulus(4'b0110, {6'd0, 6'd11, 6'd10, 6'd0}, {32'd0, 32'hD1D1, 32'hB0B0, 32'd0}, 1'b0);
    applyStimulus(4'b0001, {18'd0, 6'd7}, {96'd0, 32'h7777}, 1'b1);
    idle(4);

    $display("[TB] async reset mid-broadcast");
    applyStimulus(4'b0001, {18'd0, 6'd9}, {96'd0, 32'h9999_1234}, 1'b0);
    applyStimulus(4'b0010, {12'd0, 6'd12, 6'd0}, {64'd0, 32'h1212, 32'd0}, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_w_en", 64'(cdb_w_en), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_w_en", 64'(cdb_w_en), 64'd0);
    checkOutput("async_w_addr", 64'(cdb_w_addr), 64'd0);
    checkOutput("async_din", 64'(cdb_din), 64'd0);
    checkOutput("async_pending", 64'(cdb_pending), 64'd0);
    vld = '0;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(4'b1111, {6'd44, 6'd33, 6'd22, 6'd11},
                  {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 1'b0);
    idle(6);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = ($urandom_range(0, 99) < 45);
        t[i*TW +: TW] = ($urandom_range(0, 9) == 0) ? TW'(0) : TW'($urandom_range(1, 47));
        d[i*DW +: DW] = $urandom;
      end
      applyStimulus(v, t, d, ($urandom_range(0, 29) == 0));
    end
    idle(8);
    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus producer: collects completed results from the integer, multiply, divide and load/store execution units and issues at most one result per cycle onto the CDB write port of the physical register file (PRF). The PRF forwards that broadcast to its read ports. Each source has a one-entry holding register with a valid/ready handshake. A round-robin arbiter picks among held entries, and the winning result is registered onto the CDB.

## Interface
Parameters:
- DATA_WIDTH, 32, result data width (matches PRF word)
- TAG_WIDTH, 6, physical register address width (48-entry PRF)

Ports (`<s>` ∈ {int, mult, div, lsq}):
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered results (mispredict recovery)
- `<s>`_valid  input  1  source presents a completed result
- `<s>`_ready  output  1  block will accept the result at this edge
- `<s>`_tag  input  TAG_WIDTH  destination physical register
- `<s>`_data  input  DATA_WIDTH  result value
- cdb_w_en  output  1  CDB broadcast valid (to PRF write enable)
- cdb_w_addr  output  TAG_WIDTH  CDB destination tag
- cdb_din  output  DATA_WIDTH  CDB data
- cdb_pending  output  4  holding-register valid bits, bit order {lsq, div, mult, int}

## Operation
- Holding register per source: hold_v, hold_tag, hold_data.
- Ready rule: `<s>`_ready = !flush && (!hold_v[s] || grant[s]). It is combinational, so a granted source can refill in the same cycle.
- Accept: at an edge where `<s>`_valid && `<s>`_ready, the holding register loads the tag and data, and hold_v is set.
- Tag 0 (no destination): the handshake completes normally, hold_v is not set and no CDB slot is used.
- Arbitration:
  - Candidates are the sources with hold_v set.
  - Round-robin priority pointer ptr[1:0] (0=int, 1=mult, 2=div, 3=lsq).
  - Search starts at ptr and wraps.
  - After a grant to s, ptr ← (s+1) mod 4. With no grant, ptr is unchanged.
- Grant effect at the edge:
  - hold_v[s] is cleared, unless a new accept on s sets it in the same edge.
  - cdb_w_en←1, cdb_w_addr←hold_tag[s], cdb_din←hold_data[s].
- No grant: cdb_w_en←0; cdb_w_addr and cdb_din keep their last values.
- Flush:
  - At the edge, clears all hold_v and drives cdb_w_en←0.
  - Takes priority over accept and grant in the same cycle; ptr is unchanged.
  - A broadcast already on the CDB during the flush cycle is not retracted.
- Reset values: hold_v=0, ptr=0, cdb_w_en=0, cdb_w_addr=0, cdb_din=0, cdb_pending=0, all ready outputs 1 (once reset deasserts and flush=0).

## Timing
- Latency: a result accepted at edge E is granted at the earliest in the cycle after E and is visible on the CDB after edge E+1, for exactly one cycle. Minimum latency is 2 edges.
- Throughput:
  - Aggregate: 1 broadcast per cycle.
  - Single active source: 1 result per cycle via the pass-through ready.
- Starvation bound: a held entry is granted within 4 cycles.
- Reset mid-operation: asynchronous clear of all state. cdb_w_en drops immediately, with no clock edge required. In-flight handshakes are lost.
- Simultaneous flush and reset: reset wins.
- Outputs cdb_* are registered only. `<s>`_ready depends combinationally on flush and internal state, never on `<s>`_valid.

## Structure
- Shared package (cdb_pkg):
  - DATA_WIDTH and TAG_WIDTH constants.
  - Source index constants SRC_INT=0, SRC_MULT=1, SRC_DIV=2, SRC_LSQ=3.
  - NUM_CDB_SRC=4.
  - These are also used by the issue queues for CDB tag snooping.
- Sub-module rr_arbiter4:
  - Inputs: req[3:0], advance. Outputs: one-hot grant[3:0].
  - Holds the ptr register internally.
  - Reused later for the issue-queue select logic.

## Test plan
- Single result: int_valid=1, tag=5, data=0xDEADBEEF for one cycle after reset → cdb_w_en=1, addr=5, din=0xDEADBEEF exactly 2 edges later, for 1 cycle only; int_ready stays 1.
- Four simultaneous results: all sources valid in one cycle with tags 1,2,3,4 (int..lsq) after reset:
  - Broadcasts appear in consecutive cycles in order int, mult, div, lsq.
  - cdb_pending goes 4'b1111→1110→1100→1000→0000.
  - mult_ready=0 until mult is granted.
- Fairness: int and div valid every cycle with distinct tags → CDB alternates int, div, int, div…; int_ready and div_ready each high every other cycle.
- Tag 0: lsq_valid with tag=0 → handshake completes, cdb_pending[3] stays 0, no cdb_w_en pulse.
- Flush: mult and div held, flush=1 together with int_valid (tag 7) in the same cycle → all ready outputs 0 during flush, cdb_pending=0 next cycle, no broadcast of tag 7 or the held entries.
- Asynchronous reset mid-operation: assert reset between clock edges while cdb_w_en=1 → cdb_w_en, cdb_w_addr, cdb_din and cdb_pending go to 0 before the next edge. After release, the first grant starts from int (ptr=0).
